// File: rtl/mem_cdb_wb_arbiter.sv
// Purpose: picks one writeback per cycle for the shared CDB port (ALU, queued MEM head, or MEM bypass).
// Latency: a granted beat is on cdb_* one cycle after selection; a colliding MEM beat waits in an in-order queue.
// Backpressure: none toward MEM; a full queue drops the new MEM beat and sets sticky overflow_o. STARVATION_GUARD_EN adds an age guard driving alu_stall_o.
module mem_cdb_wb_arbiter #(
    parameter int QDEPTH    = 4
`ifdef STARVATION_GUARD_EN
    ,
    parameter int AGE_LIMIT = 8
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid_i,
    input  logic [2:0]                 mem_warpID_i,
    input  logic [4:0]                 mem_reg_addr_i,
    input  logic [7:0]                 mem_mask_i,
    input  logic [255:0]               mem_data_i,
    input  logic [31:0]                mem_Instr_i,
    input  logic                       alu_valid_i,
    input  logic [2:0]                 alu_warpID_i,
    input  logic [4:0]                 alu_reg_addr_i,
    input  logic [7:0]                 alu_mask_i,
    input  logic [255:0]               alu_data_i,
    input  logic [31:0]                alu_Instr_i,
    output logic                       cdb_valid_o,
    output logic                       cdb_src_mem_o,
    output logic [2:0]                 cdb_warpID_o,
    output logic [4:0]                 cdb_reg_addr_o,
    output logic [7:0]                 cdb_mask_o,
    output logic [255:0]               cdb_data_o,
    output logic [31:0]                cdb_Instr_o,
    output logic [$clog2(QDEPTH):0]    q_count_o,
    output logic                       overflow_o,
    output logic                       alu_stall_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // One writeback beat as carried on the CDB.
    typedef struct packed {
        logic [2:0]   warp;
        logic [4:0]   reg_addr;
        logic [7:0]   mask;
        logic [255:0] data;
        logic [31:0]  instr;
    } wb_t;

    // Queue state
    wb_t             r_q [0:QDEPTH-1];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // Output register
    wb_t             r_cdb;
    logic            r_cdb_valid;
    logic            r_cdb_src_mem;
    logic            r_overflow;

    // Arbitration wires
    wb_t             w_mem_in;
    wb_t             w_alu_in;
    wb_t             w_head;
    wb_t             w_sel;
    logic            w_q_empty;
    logic            w_q_full;
    logic            w_stall_prio;
    logic            w_alu_viol;
    logic            w_grant_alu;
    logic            w_grant_head;
    logic            w_grant_byp;
    logic            w_grant_any;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_do_push;

    assign w_mem_in  = '{warp: mem_warpID_i, reg_addr: mem_reg_addr_i, mask: mem_mask_i,
                         data: mem_data_i, instr: mem_Instr_i};
    assign w_alu_in  = '{warp: alu_warpID_i, reg_addr: alu_reg_addr_i, mask: alu_mask_i,
                         data: alu_data_i, instr: alu_Instr_i};
    assign w_head    = r_q[r_rd_ptr];
    assign w_q_empty = (r_count == '0);
    assign w_q_full  = (r_count == CW'(QDEPTH));

`ifdef STARVATION_GUARD_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [AW-1:0] r_age;
    logic          r_alu_stall;

    // Age of the waiting head; stall is raised one cycle after the age saturates and dropped after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_age       <= '0;
            r_alu_stall <= 1'b0;
        end else if (w_pop || w_q_empty) begin
            r_age       <= '0;
            r_alu_stall <= 1'b0;
        end else begin
            if (r_age != AW'(AGE_LIMIT)) begin
                r_age <= r_age + AW'(1);
            end
            r_alu_stall <= (r_age == AW'(AGE_LIMIT));
        end
    end

    assign w_stall_prio = r_alu_stall;
    // An ALU beat during a stall was not supposed to be issued; it is lost.
    assign w_alu_viol   = r_alu_stall & alu_valid_i;
    assign alu_stall_o  = r_alu_stall;
`else
    assign w_stall_prio = 1'b0;
    assign w_alu_viol   = 1'b0;
    assign alu_stall_o  = 1'b0;
`endif

    // Grant selection: ALU first, then queued MEM head, then MEM bypass only into an empty queue.
    always_comb begin
        w_grant_alu  = 1'b0;
        w_grant_head = 1'b0;
        w_grant_byp  = 1'b0;
        if (w_stall_prio) begin
            if (!w_q_empty) begin
                w_grant_head = 1'b1;
            end else if (mem_valid_i) begin
                w_grant_byp = 1'b1;
            end
        end else if (alu_valid_i) begin
            w_grant_alu = 1'b1;
        end else if (!w_q_empty) begin
            w_grant_head = 1'b1;
        end else if (mem_valid_i) begin
            w_grant_byp = 1'b1;
        end
    end

    assign w_grant_any = w_grant_alu | w_grant_head | w_grant_byp;
    assign w_pop       = w_grant_head;
    // A MEM beat that did not bypass must be queued; it is lost only if no slot frees this cycle.
    assign w_push      = mem_valid_i & ~w_grant_byp;
    assign w_drop      = w_push & w_q_full & ~w_pop;
    assign w_do_push   = w_push & ~w_drop;

    // Payload mux feeding the output register.
    always_comb begin
        w_sel = w_alu_in;
        if (w_grant_head) begin
            w_sel = w_head;
        end else if (w_grant_byp) begin
            w_sel = w_mem_in;
        end
    end

    // Queue storage: tail write on an accepted push; payload needs no reset since pointers guard it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_q[r_wr_ptr] <= w_mem_in;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // CDB output register: strobe every cycle, payload only updated on a grant so it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid   <= 1'b0;
            r_cdb_src_mem <= 1'b0;
            r_cdb         <= '0;
        end else begin
            r_cdb_valid <= w_grant_any;
            if (w_grant_any) begin
                r_cdb         <= w_sel;
                r_cdb_src_mem <= w_grant_head | w_grant_byp;
            end
        end
    end

    // Sticky loss flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop || w_alu_viol) begin
            r_overflow <= 1'b1;
        end
    end

    assign cdb_valid_o    = r_cdb_valid;
    assign cdb_src_mem_o  = r_cdb_src_mem;
    assign cdb_warpID_o   = r_cdb.warp;
    assign cdb_reg_addr_o = r_cdb.reg_addr;
    assign cdb_mask_o     = r_cdb.mask;
    assign cdb_data_o     = r_cdb.data;
    assign cdb_Instr_o    = r_cdb.instr;
    assign q_count_o      = r_count;
    assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_mem_cdb_wb_arbiter.sv
// Bench for mem_cdb_wb_arbiter: directed vector table, hand sequence, randomized run against a queue model.
module tb_mem_cdb_wb_arbiter;

    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [2:0]   w;
        logic [4:0]   r;
        logic [7:0]   m;
        logic [255:0] d;
        logic [31:0]  i;
    } ent_t;

    typedef struct {
        logic       rst;
        logic       av;
        logic [4:0] a_reg;
        logic       mv;
        logic [4:0] m_reg;
        logic       e_v;
        logic       e_src;
        logic [4:0] e_reg;
        logic [2:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_valid_i;
    logic [2:0]   mem_warpID_i;
    logic [4:0]   mem_reg_addr_i;
    logic [7:0]   mem_mask_i;
    logic [255:0] mem_data_i;
    logic [31:0]  mem_Instr_i;
    logic         alu_valid_i;
    logic [2:0]   alu_warpID_i;
    logic [4:0]   alu_reg_addr_i;
    logic [7:0]   alu_mask_i;
    logic [255:0] alu_data_i;
    logic [31:0]  alu_Instr_i;
    logic         cdb_valid_o;
    logic         cdb_src_mem_o;
    logic [2:0]   cdb_warpID_o;
    logic [4:0]   cdb_reg_addr_o;
    logic [7:0]   cdb_mask_o;
    logic [255:0] cdb_data_o;
    logic [31:0]  cdb_Instr_o;
    logic [2:0]   q_count_o;
    logic         overflow_o;
    logic         alu_stall_o;

    int n_chk  = 0;
    int n_pass = 0;

    vec_t vq[$];

    // Reference model state
    ent_t mq[$];
    ent_t e_out;
    logic e_v;
    logic e_src;
    logic e_ovf;

    always #5 clk = ~clk;

    mem_cdb_wb_arbiter #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_warpID_i(mem_warpID_i), .mem_reg_addr_i(mem_reg_addr_i),
        .mem_mask_i(mem_mask_i), .mem_data_i(mem_data_i), .mem_Instr_i(mem_Instr_i),
        .alu_valid_i(alu_valid_i), .alu_warpID_i(alu_warpID_i), .alu_reg_addr_i(alu_reg_addr_i),
        .alu_mask_i(alu_mask_i), .alu_data_i(alu_data_i), .alu_Instr_i(alu_Instr_i),
        .cdb_valid_o(cdb_valid_o), .cdb_src_mem_o(cdb_src_mem_o), .cdb_warpID_o(cdb_warpID_o),
        .cdb_reg_addr_o(cdb_reg_addr_o), .cdb_mask_o(cdb_mask_o), .cdb_data_o(cdb_data_o),
        .cdb_Instr_o(cdb_Instr_o), .q_count_o(q_count_o), .overflow_o(overflow_o),
        .alu_stall_o(alu_stall_o)
    );

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic av, input ent_t a, input logic mv, input ent_t m);
        rst            = r;
        alu_valid_i    = av;
        alu_warpID_i   = a.w;
        alu_reg_addr_i = a.r;
        alu_mask_i     = a.m;
        alu_data_i     = a.d;
        alu_Instr_i    = a.i;
        mem_valid_i    = mv;
        mem_warpID_i   = m.w;
        mem_reg_addr_i = m.r;
        mem_mask_i     = m.m;
        mem_data_i     = m.d;
        mem_Instr_i    = m.i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Deterministic payload keyed by register number, so a beat can be identified from any field.
    function automatic ent_t tag_ent(input logic [4:0] r);
        ent_t e;
        e.w = r[2:0];
        e.r = r;
        e.m = {3'b000, r} ^ 8'hA5;
        e.d = {8{27'h0, r}} ^ {8{32'h5A00_0000}};
        e.i = {27'h0, r} | 32'h1000_0000;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.w = 3'($urandom);
        e.r = 5'($urandom);
        e.m = 8'($urandom);
        for (int k = 0; k < 8; k++) e.d[k*32 +: 32] = $urandom;
        e.i = $urandom;
        return e;
    endfunction

    task automatic row(input int r, input int av, input int ar, input int mv, input int mr,
                       input int ev, input int es, input int er, input int ec, input int eo);
        vec_t v;
        v.rst = r[0];  v.av = av[0]; v.a_reg = ar[4:0]; v.mv = mv[0]; v.m_reg = mr[4:0];
        v.e_v = ev[0]; v.e_src = es[0]; v.e_reg = er[4:0]; v.e_cnt = ec[2:0]; v.e_ovf = eo[0];
        vq.push_back(v);
    endtask

    // Behavioural model of one cycle: pick a winner by priority, then queue or drop the MEM beat.
    task automatic model_step(input logic r, input logic av, input ent_t a, input logic mv, input ent_t m);
        logic bypassed;
        bypassed = 1'b0;
        if (r) begin
            mq.delete();
            e_out = '0;
            e_v   = 1'b0;
            e_src = 1'b0;
            e_ovf = 1'b0;
        end else begin
            e_v = 1'b0;
            if (av) begin
                e_v = 1'b1; e_src = 1'b0; e_out = a;
            end else if (mq.size() > 0) begin
                e_v = 1'b1; e_src = 1'b1; e_out = mq.pop_front();
            end else if (mv) begin
                e_v = 1'b1; e_src = 1'b1; e_out = m; bypassed = 1'b1;
            end
            if (mv && !bypassed) begin
                if (mq.size() < QDEPTH) mq.push_back(m);
                else e_ovf = 1'b1;
            end
        end
    endtask

    initial begin
        ent_t a;
        ent_t m;
        logic rs, av, mv;

        // rst av ar mv mr | v src reg cnt ovf
        row(1, 0,  0, 0,  0,  0, 0,  0, 0, 0);
        row(0, 0,  0, 1,  7,  1, 1,  7, 0, 0);
        row(0, 0,  0, 0,  0,  0, 0,  7, 0, 0);
        row(0, 1,  1, 1,  2,  1, 0,  1, 1, 0);
        row(0, 0,  0, 0,  0,  1, 1,  2, 0, 0);
        row(0, 1, 10, 1, 20,  1, 0, 10, 1, 0);
        row(0, 1, 11, 1, 21,  1, 0, 11, 2, 0);
        row(0, 1, 12, 1, 22,  1, 0, 12, 3, 0);
        row(0, 1, 13, 1, 23,  1, 0, 13, 4, 0);
        row(0, 1, 14, 1, 24,  1, 0, 14, 4, 1);
        row(0, 1, 15, 0,  0,  1, 0, 15, 4, 1);
        row(0, 0,  0, 1, 25,  1, 1, 20, 4, 1);
        row(0, 0,  0, 0,  0,  1, 1, 21, 3, 1);
        row(0, 0,  0, 0,  0,  1, 1, 22, 2, 1);
        row(0, 0,  0, 0,  0,  1, 1, 23, 1, 1);
        row(0, 0,  0, 0,  0,  1, 1, 25, 0, 1);
        row(0, 0,  0, 0,  0,  0, 0, 25, 0, 1);
        row(0, 1,  1, 1,  2,  1, 0,  1, 1, 1);
        row(0, 1,  3, 1,  4,  1, 0,  3, 2, 1);
        row(0, 1,  5, 1,  6,  1, 0,  5, 3, 1);
        row(1, 1,  8, 1,  9,  0, 0,  0, 0, 0);
        row(0, 0,  0, 0,  0,  0, 0,  0, 0, 0);
        row(0, 0,  0, 0,  0,  0, 0,  0, 0, 0);
        row(0, 0,  0, 1,  9,  1, 1,  9, 0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].rst, vq[k].av, tag_ent(vq[k].a_reg), vq[k].mv, tag_ent(vq[k].m_reg));
            tick();
            chk($sformatf("vec%0d_ctrl", k),
                {cdb_valid_o, cdb_valid_o & cdb_src_mem_o, cdb_reg_addr_o, q_count_o, overflow_o},
                {vq[k].e_v, vq[k].e_src, vq[k].e_reg, vq[k].e_cnt, vq[k].e_ovf});
            if (vq[k].e_v)
                chk($sformatf("vec%0d_payload", k),
                    {cdb_warpID_o, cdb_reg_addr_o, cdb_mask_o, cdb_data_o, cdb_Instr_o},
                    tag_ent(vq[k].e_reg));
        end

        // Hand sequence: idle-queue bypass carrying lane0 = DEADBEEF, then the held payload.
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        m = '0;
        m.w = 3'd3; m.r = 5'd7; m.m = 8'hFF; m.i = 32'h1234_5678;
        m.d[31:0] = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, '0, 1'b1, m);
        tick();
        chk("bypass_valid_src_cnt", {cdb_valid_o, cdb_src_mem_o, q_count_o}, {1'b1, 1'b1, 3'd0});
        chk("bypass_warp_reg", {cdb_warpID_o, cdb_reg_addr_o}, {3'd3, 5'd7});
        chk("bypass_lane0", cdb_data_o[31:0], 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        chk("idle_after_bypass", {cdb_valid_o, q_count_o, alu_stall_o}, {1'b0, 3'd0, 1'b0});
        chk("hold_lane0", cdb_data_o[31:0], 32'hDEAD_BEEF);

        // Randomized run against the model.
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        model_step(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 199) == 0);
            av = ($urandom_range(0, 99) < 55);
            mv = ($urandom_range(0, 99) < 50);
            a  = rnd_ent();
            m  = rnd_ent();
            drive(rs, av, a, mv, m);
            model_step(rs, av, a, mv, m);
            tick();
            chk($sformatf("rnd%0d_ctrl", c),
                {cdb_valid_o, cdb_valid_o & cdb_src_mem_o, q_count_o, overflow_o, alu_stall_o},
                {e_v, e_v & e_src, 3'(mq.size()), e_ovf, 1'b0});
            chk($sformatf("rnd%0d_payload", c),
                {cdb_warpID_o, cdb_reg_addr_o, cdb_mask_o, cdb_data_o, cdb_Instr_o}, e_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
